// File: rtl/mult_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_if
//  Description : Handshake/data bundle between decode/register_file and the
//                HI/LO multiply/divide unit.
//                master modport (decode side) drives:
//                  start, op, operand_a, operand_b,
//                  hilo_write_en, hilo_sel, hilo_write_data
//                slave modport (mult_div_unit) drives:
//                  busy, done, hi, lo
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             hilo_write_en;
    logic             hilo_sel;
    logic [WIDTH-1:0] hilo_write_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b,
        output hilo_write_en, hilo_sel, hilo_write_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        input  hilo_write_en, hilo_sel, hilo_write_data,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU)
//                owning the architectural HI/LO registers (MFHI/MFLO read,
//                MTHI/MTLO write). IDLE -> ITER (WIDTH steps) -> FIN -> IDLE.
//  Ports       : clk, rst (synchronous, active-high)
//                bus (mult_div_if.slave):
//                  start, op[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU),
//                  operand_a, operand_b, hilo_write_en, hilo_sel,
//                  hilo_write_data -> busy, done, hi, lo
//  Config      : MULT_FAST_EN - when defined, MULT/MULTU use a native
//                multiplier (latency 2); DIV/DIVU stay iterative.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mult_div_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_iter = 2'd1;
    localparam logic [1:0] c_fin  = 2'd2;
`ifdef MULT_FAST_EN
    localparam logic [1:0] c_fast = 2'd3;
`endif

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic               r_is_div;
    logic               r_neg_res;   // product/quotient must be negated
    logic               r_neg_rem;   // remainder takes the dividend's sign
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_mcand;     // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0] r_acc;       // MUL: {partial, multiplier}; DIV: low half = quotient
    logic [WIDTH-1:0]   r_rem;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Operand magnitudes; unsigned ops (op[0]=1) pass raw values through.
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.operand_a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.operand_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.operand_a : bus.operand_a;
    assign w_b_mag  = w_b_neg ? -bus.operand_b : bus.operand_b;

    // Shift-add step: carry out of the upper half lands in the MSB after the shift.
    logic [WIDTH:0] w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    // Restoring divide step: the shifted remainder needs WIDTH+1 bits.
    logic [WIDTH:0] w_div_shift;
    logic [WIDTH:0] w_div_diff;
    assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mcand};

    // Sign fix-up. A zero divisor yields an all-ones quotient regardless of
    // sign; the remainder naturally equals operand_a in that case.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_remd;
    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quot = r_div_zero ? {WIDTH{1'b1}}
                  : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_remd = r_neg_rem ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    // start has priority; a simultaneous MTHI/MTLO is dropped.
                    if (bus.start) begin
                        r_busy     <= 1'b1;
                        r_count    <= '0;
                        r_is_div   <= bus.op[1];
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= bus.op[1] & w_a_neg;
                        r_div_zero <= bus.op[1] & (bus.operand_b == '0);
                        r_rem      <= '0;
                        if (bus.op[1]) begin
                            r_mcand <= w_b_mag;
                            r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                            r_state <= c_iter;
                        end else begin
                            r_mcand <= w_a_mag;
                            r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
`ifdef MULT_FAST_EN
                            r_state <= c_fast;
`else
                            r_state <= c_iter;
`endif
                        end
                    end else if (bus.hilo_write_en) begin
                        if (bus.hilo_sel) begin
                            r_hi <= bus.hilo_write_data;
                        end else begin
                            r_lo <= bus.hilo_write_data;
                        end
                    end
                end

                c_iter: begin
                    r_count <= r_count + CW'(1);
                    if (r_is_div) begin
                        if (!w_div_diff[WIDTH]) begin
                            r_rem              <= w_div_diff[WIDTH-1:0];
                            r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem              <= w_div_shift[WIDTH-1:0];
                            r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                    if (r_count == c_last) begin
                        r_state <= c_fin;
                    end
                end

`ifdef MULT_FAST_EN
                c_fast: begin
                    r_acc   <= {{WIDTH{1'b0}}, r_mcand} * {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
                    r_state <= c_fin;
                end
`endif

                c_fin: begin
                    if (r_is_div) begin
                        r_lo <= w_quot;
                        r_hi <= w_remd;
                    end else begin
                        r_lo <= w_prod[WIDTH-1:0];
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. Results are compared
//                against a 64-bit arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;
    localparam int WIDTH = 32;
`ifdef MULT_FAST_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_if #(.WIDTH(WIDTH)) bus();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    // Reference: MIPS HI/LO semantics from plain arithmetic.
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint      p;
        logic [63:0] u;
        int          q;
        int          r;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                u  = {32'b0, a} * {32'b0, b};
                hi = u[63:32];
                lo = u[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (op == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        lo = 32'h8000_0000;
                        hi = 32'd0;
                    end else begin
                        q  = $signed(a) / $signed(b);
                        r  = $signed(a) % $signed(b);
                        lo = q;
                        hi = r;
                    end
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        return op[1] ? DIV_LAT : MUL_LAT;
    endfunction

    // Issues one op and waits for done; lat = -1 on timeout. Operands are
    // scrambled right after the start edge to show they are not re-sampled.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic we, input logic [31:0] wdata, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.hilo_write_en = we;
        bus.hilo_sel = 1'b0;
        bus.hilo_write_data = wdata;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.hilo_write_en = 1'b0;
        bus.op = 2'($urandom);
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 20));
            1: return -32'($urandom_range(1, 20));
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mult();
        logic [1:0]  op;
        logic [31:0] a, b;
        int          lat;
        for (int i = 0; i < 22; i++) begin
            if (i == 0) begin op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
            else if (i == 1) begin op = 2'b00; a = -32'd7; b = 32'd3; end
            else begin op = 2'($urandom_range(0, 1)); a = rnd_operand(); b = rnd_operand(); end
            ref_op(op, a, b, exp_hi, exp_lo);
            run_op(op, a, b, 1'b0, 32'd0, lat);
            checks++; if (lat != MUL_LAT) begin failures++; $display("FAIL mul_latency op=%0d got=%0d exp=%0d", op, lat, MUL_LAT); end
            checks++; if (bus.hi !== exp_hi) begin failures++; $display("FAIL mul_hi op=%0d a=%h b=%h got=%h exp=%h", op, a, b, bus.hi, exp_hi); end
            checks++; if (bus.lo !== exp_lo) begin failures++; $display("FAIL mul_lo op=%0d a=%h b=%h got=%h exp=%h", op, a, b, bus.lo, exp_lo); end
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mul_busy_at_done got=%b exp=0", bus.busy); end
            @(posedge clk);
            #1;
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mul_done_pulse got=%b exp=0", bus.done); end
        end
    endtask

    task automatic test_div();
        logic [1:0]  op;
        logic [31:0] a, b;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            case (i)
                0: begin op = 2'b10; a = -32'd7; b = 32'd2; end
                1: begin op = 2'b11; a = 32'd100; b = 32'd0; end
                2: begin op = 2'b10; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: begin op = 2'b10; a = -32'd9; b = 32'd0; end
                default: begin
                    op = 2'($urandom_range(2, 3));
                    a  = rnd_operand();
                    b  = ($urandom_range(0, 4) == 0) ? 32'd0 : rnd_operand();
                end
            endcase
            ref_op(op, a, b, exp_hi, exp_lo);
            run_op(op, a, b, 1'b0, 32'd0, lat);
            checks++; if (lat != DIV_LAT) begin failures++; $display("FAIL div_latency op=%0d got=%0d exp=%0d", op, lat, DIV_LAT); end
            checks++; if (bus.hi !== exp_hi) begin failures++; $display("FAIL div_hi op=%0d a=%h b=%h got=%h exp=%h", op, a, b, bus.hi, exp_hi); end
            checks++; if (bus.lo !== exp_lo) begin failures++; $display("FAIL div_lo op=%0d a=%h b=%h got=%h exp=%h", op, a, b, bus.lo, exp_lo); end
        end
    endtask

    task automatic test_ignored_inputs();
        logic [31:0] a, b;
        int          ndone;
        int          lat;
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        ref_op(2'b11, a, b, exp_hi, exp_lo);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = a; bus.operand_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        lat = -1;
        for (int n = 1; n <= 70; n++) begin
            if (n == 5) begin
                bus.start = 1'b1; bus.op = 2'b01;
                bus.operand_a = $urandom; bus.operand_b = $urandom;
                bus.hilo_write_en = 1'b1; bus.hilo_sel = 1'($urandom); bus.hilo_write_data = $urandom;
            end
            if (n == 9) begin
                bus.start = 1'b0;
                bus.hilo_write_en = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL ignored_done_count got=%0d exp=1", ndone); end
        checks++; if (lat != DIV_LAT) begin failures++; $display("FAIL ignored_latency got=%0d exp=%0d", lat, DIV_LAT); end
        checks++; if (bus.hi !== exp_hi) begin failures++; $display("FAIL ignored_hi got=%h exp=%h", bus.hi, exp_hi); end
        checks++; if (bus.lo !== exp_lo) begin failures++; $display("FAIL ignored_lo got=%h exp=%h", bus.lo, exp_lo); end
    endtask

    task automatic test_hilo_write();
        logic [31:0] d, a, b;
        int          lat;
        // MTHI 5
        @(negedge clk);
        bus.hilo_write_en = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_write_data = 32'd5;
        @(posedge clk);
        #1;
        bus.hilo_write_en = 1'b0;
        exp_hi = 32'd5;
        checks++; if (bus.hi !== exp_hi) begin failures++; $display("FAIL mthi_hi got=%h exp=%h", bus.hi, exp_hi); end
        checks++; if (bus.lo !== exp_lo) begin failures++; $display("FAIL mthi_lo_held got=%h exp=%h", bus.lo, exp_lo); end
        // MTLO random
        d = $urandom;
        @(negedge clk);
        bus.hilo_write_en = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_write_data = d;
        @(posedge clk);
        #1;
        bus.hilo_write_en = 1'b0;
        exp_lo = d;
        checks++; if (bus.lo !== exp_lo) begin failures++; $display("FAIL mtlo_lo got=%h exp=%h", bus.lo, exp_lo); end
        checks++; if (bus.hi !== exp_hi) begin failures++; $display("FAIL mtlo_hi_held got=%h exp=%h", bus.hi, exp_hi); end
        // start and write together: start wins, write dropped
        a = rnd_operand();
        b = rnd_operand();
        ref_op(2'b00, a, b, exp_hi, exp_lo);
        run_op(2'b00, a, b, 1'b1, $urandom, lat);
        checks++; if (lat != MUL_LAT) begin failures++; $display("FAIL start_wr_latency got=%0d exp=%0d", lat, MUL_LAT); end
        checks++; if (bus.hi !== exp_hi) begin failures++; $display("FAIL start_wr_hi got=%h exp=%h", bus.hi, exp_hi); end
        checks++; if (bus.lo !== exp_lo) begin failures++; $display("FAIL start_wr_lo got=%h exp=%h", bus.lo, exp_lo); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op1, op2;
        logic [31:0] a, b;
        int          lat;
        for (int k = 0; k < 3; k++) begin
            op1 = 2'($urandom);
            a = rnd_operand(); b = rnd_operand();
            ref_op(op1, a, b, exp_hi, exp_lo);
            run_op(op1, a, b, 1'b0, 32'd0, lat);
            checks++; if (lat != lat_of(op1)) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, lat_of(op1)); end
            checks++; if (bus.lo !== exp_lo) begin failures++; $display("FAIL b2b_first_lo got=%h exp=%h", bus.lo, exp_lo); end
            // Now in the done cycle: issue the second op immediately.
            op2 = 2'($urandom_range(2, 3));
            a = rnd_operand(); b = rnd_operand();
            bus.start = 1'b1; bus.op = op2; bus.operand_a = a; bus.operand_b = b;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_done_low got=%b exp=0", bus.done); end
            ref_op(op2, a, b, exp_hi, exp_lo);
            lat = -1;
            for (int n = 1; n <= 100; n++) begin
                @(posedge clk);
                #1;
                if (bus.done) begin lat = n; break; end
            end
            checks++; if (lat != DIV_LAT) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, DIV_LAT); end
            checks++; if (bus.hi !== exp_hi) begin failures++; $display("FAIL b2b_second_hi got=%h exp=%h", bus.hi, exp_hi); end
            checks++; if (bus.lo !== exp_lo) begin failures++; $display("FAIL b2b_second_lo got=%h exp=%h", bus.lo, exp_lo); end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] a, b;
        int          lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.operand_a = $urandom; bus.operand_b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midop_busy_before got=%b exp=1", bus.busy); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midop_rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midop_rst_done got=%b exp=0", bus.done); end
        checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL midop_rst_hi got=%h exp=0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin failures++; $display("FAIL midop_rst_lo got=%h exp=0", bus.lo); end
        @(negedge clk);
        rst = 1'b0;
        // No stale completion after reset release.
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) lat++;
        end
        checks++; if (lat != 0) begin failures++; $display("FAIL midop_stale_done got=%0d exp=0", lat); end
        a = rnd_operand();
        b = rnd_operand();
        ref_op(2'b11, a, b, exp_hi, exp_lo);
        run_op(2'b11, a, b, 1'b0, 32'd0, lat);
        checks++; if (lat != DIV_LAT) begin failures++; $display("FAIL after_rst_latency got=%0d exp=%0d", lat, DIV_LAT); end
        checks++; if (bus.hi !== exp_hi) begin failures++; $display("FAIL after_rst_hi got=%h exp=%h", bus.hi, exp_hi); end
        checks++; if (bus.lo !== exp_lo) begin failures++; $display("FAIL after_rst_lo got=%h exp=%h", bus.lo, exp_lo); end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.start           = 1'b0;
        bus.op              = 2'b00;
        bus.operand_a       = '0;
        bus.operand_b       = '0;
        bus.hilo_write_en   = 1'b0;
        bus.hilo_sel        = 1'b0;
        bus.hilo_write_data = '0;

        test_reset();
        test_mult();
        test_div();
        test_ignored_inputs();
        test_hilo_write();
        test_back_to_back();
        test_reset_mid_op();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
